ro_freq_counter: RTL

//  Measures one ring oscillator: enables the ring, counts its output edges over a fixed CLK window, then returns the ring to its stress/hold state.

---
 rtl/ro_meas_pkg.sv | 24 ++
 rtl/ro_freq_counter_if.sv | 39 +++
 rtl/ro_edge_sync.sv | 25 ++
 rtl/ro_freq_counter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg: shared FSM state type, default widths and the saturating
// increment helper for the ring-oscillator measurement block.
package ro_meas_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned WIN_W_DEF = 20;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StCount  = 2'd2,
    StDone   = 2'd3
  } ro_state_e;

  // Increment val by inc, holding at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val,
                                          input logic inc);
    logic [31:0] res;
    res = val;
    if (inc && (val < max_val)) res = val + 32'd1;
    return res;
  endfunction

endpackage

// File: rtl/ro_freq_counter_if.sv
// ro_freq_counter_if: host-side control/result signals plus the ring
// oscillator hookup. With RO_FREQ_MINMAX_EN defined it also carries the
// min/max tracking signals.
interface ro_freq_counter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stress_req;
  logic             ro_in;
  logic             ro_mode;
  logic             ro_stress;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] result;
  logic             ovf;
`ifdef RO_FREQ_MINMAX_EN
  logic             clr_mm;
  logic [CNT_W-1:0] min_res;
  logic [CNT_W-1:0] max_res;

  modport master (
    output start, stress_req, ro_in, clr_mm,
    input  ro_mode, ro_stress, busy, valid, result, ovf, min_res, max_res
  );
  modport slave (
    input  start, stress_req, ro_in, clr_mm,
    output ro_mode, ro_stress, busy, valid, result, ovf, min_res, max_res
  );
`else
  modport master (
    output start, stress_req, ro_in,
    input  ro_mode, ro_stress, busy, valid, result, ovf
  );
  modport slave (
    input  start, stress_req, ro_in,
    output ro_mode, ro_stress, busy, valid, result, ovf
  );
`endif
endinterface

// File: rtl/ro_edge_sync.sv
// ro_edge_sync: two-flop synchronizer for the asynchronous ring output plus
// a third flop for rising-edge detection. Runs continuously.
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_i,
  output logic rise_o
);
  // sync_q[0], sync_q[1] form the synchronizer; sync_q[2] is the edge-detect delay.
  logic [2:0] sync_q, sync_d;

  // Shift the ring sample through the pipeline.
  always_comb begin
    sync_d = {sync_q[1:0], ro_i};
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ro_freq_counter.sv
// ro_freq_counter: enables a ring oscillator, lets it settle, counts its
// rising edges over a fixed CLK window and then returns it to stress/hold.
// Optional feature macro: RO_FREQ_MINMAX_EN adds min/max result tracking.
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned WIN_W  = WIN_W_DEF,
  parameter int unsigned WINDOW = 4096,
  parameter int unsigned SETTLE = 16
) (
  input logic              clk,
  input logic              rst_n,
  ro_freq_counter_if.slave bus
);
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [WIN_W-1:0] SettleLd = WIN_W'(SETTLE - 1);
  localparam logic [WIN_W-1:0] WindowLd = WIN_W'(WINDOW - 1);

  ro_state_e        state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             stress_q, stress_d;
  logic             rise, accept, last_cnt;
  logic             busy, valid;

  ro_edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_i  (bus.ro_in),
    .rise_o(rise)
  );

  assign accept   = ((state_q == StIdle) || (state_q == StDone)) && bus.start;
  assign last_cnt = (state_q == StCount) && (timer_q == '0);
  assign cnt_inc  = CNT_W'(sat_inc(32'(cnt_q), 32'(CntMax), rise));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; START is only honoured while idle or done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (bus.start) state_d = StSettle;
      StSettle:       if (timer_q == '0) state_d = StCount;
      StCount:        if (timer_q == '0) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy  = (state_q == StSettle) || (state_q == StCount);
    valid = (state_q == StDone);
  end

  // Timer, edge counter, result capture and ring stress level.
  always_comb begin
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (accept) begin
      timer_d = SettleLd;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == StSettle) begin
      timer_d = (timer_q == '0) ? WindowLd : timer_q - 1'b1;
    end else if (state_q == StCount) begin
      cnt_d = cnt_inc;
      // OVF marks an edge lost because the counter was already full.
      if (rise && (cnt_q == CntMax)) ovf_d = 1'b1;
      if (timer_q != '0) timer_d = timer_q - 1'b1;
      if (last_cnt) result_d = cnt_inc;
    end
    // Stress only applies while the ring is parked (idle/done next cycle).
    stress_d = ((state_d == StIdle) || (state_d == StDone)) ? bus.stress_req : 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      stress_q <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      stress_q <= stress_d;
    end
  end

  assign bus.ro_mode   = busy;
  assign bus.ro_stress = stress_q;
  assign bus.busy      = busy;
  assign bus.valid     = valid;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;

`ifdef RO_FREQ_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;

  // Track extremes of completed windows; a clear overrides a same-cycle update.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (bus.clr_mm) begin
      min_d = '1;
      max_d = '0;
    end else if (last_cnt) begin
      if (cnt_inc < min_q) min_d = cnt_inc;
      if (cnt_inc > max_q) max_d = cnt_inc;
    end
  end

  // Min/max registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign bus.min_res = min_q;
  assign bus.max_res = max_q;
`endif

endmodule
